// File: rtl/can_rx_deframer_if.sv
// Bus-side signals of the CAN 2.0A receive deframer: serial bit in, ACK slot drive,
// and the host-facing frame outputs.
interface can_rx_deframer_if #(
    parameter int unsigned MAX_BYTES = 8
);
    logic       bit_in;
    logic       ack_out;
    logic       RX_BUSY;
    logic       RX_VALID;
    logic       RX_ERR;
    logic [1:0] RX_ERR_CODE;
    logic [10:0] RX_ID;
    logic [3:0] RX_DLC;
    logic [7:0] RX_DATA [MAX_BYTES-1:0];
    logic       RX_RTR;

    modport master (
        output bit_in,
        input  ack_out, RX_BUSY, RX_VALID, RX_ERR, RX_ERR_CODE,
        input  RX_ID, RX_DLC, RX_DATA, RX_RTR
    );

    modport slave (
        input  bit_in,
        output ack_out, RX_BUSY, RX_VALID, RX_ERR, RX_ERR_CODE,
        output RX_ID, RX_DLC, RX_DATA, RX_RTR
    );
endinterface

// File: rtl/can_rx_deframer.sv
// CAN 2.0A base-frame receiver: destuffs, checks CRC-15 and fixed-form bits, drives the
// ACK slot and hands ID/DLC/payload to the host with one-cycle valid/error strobes.
module can_rx_deframer #(
    parameter int unsigned MAX_BYTES = 8,
    parameter int unsigned IDLE_BITS = 11
) (
    input logic              clk,
    input logic              rst,
    can_rx_deframer_if.slave bus
);
    localparam int unsigned IW      = $clog2(IDLE_BITS + 1);
    localparam logic [3:0]  MAX_DLC = 4'(MAX_BYTES);

    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_CTRL, S_DATA, S_CRC,
        S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_WAIT_IDLE
    } state_t;

    state_t        state_q;
    logic [2:0]    run_q;
    logic          prev_q;
    logic [14:0]   crc_q;
    logic [13:0]   crc_rx_q;
    logic          crc_ok_q;
    logic [5:0]    cnt_q;
    logic [IW-1:0] idle_q;
    logic [10:0]   id_q;
    logic          rtr_q;
    logic [3:0]    dlc_q;
    logic [2:0]    last_byte_q;
    logic [7:0]    data_q [MAX_BYTES-1:0];

    logic          in_stuff;
    logic          stuff_slot;
    logic [14:0]   crc_d;
    logic [3:0]    dlc_d;
    logic [3:0]    nbytes;
    logic [1:0]    err_d;

    always_comb begin
        in_stuff   = state_q inside {S_ID, S_CTRL, S_DATA, S_CRC};
        stuff_slot = in_stuff && (run_q == 3'd5);
        crc_d      = {crc_q[13:0], 1'b0} ^ ((bus.bit_in ^ crc_q[14]) ? 15'h4599 : 15'h0000);
        dlc_d      = {dlc_q[2:0], bus.bit_in};
        if (rtr_q)                nbytes = '0;
        else if (dlc_d > MAX_DLC) nbytes = MAX_DLC;
        else                      nbytes = dlc_d;

        // 1 = stuff, 2 = CRC, 3 = form; a stuff slot masks every other check
        err_d = 2'd0;
        if (stuff_slot) begin
            if (bus.bit_in == prev_q) err_d = 2'd1;
        end else begin
            case (state_q)
                S_CTRL:           if ((cnt_q == 6'd1 || cnt_q == 6'd2) && bus.bit_in) err_d = 2'd3;
                S_CRC_DEL, S_EOF: if (!bus.bit_in) err_d = 2'd3;
                S_ACK_DEL: begin
                    if (!crc_ok_q)        err_d = 2'd2;
                    else if (!bus.bit_in) err_d = 2'd3;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            run_q           <= '0;
            prev_q          <= 1'b1;
            crc_q           <= '0;
            crc_rx_q        <= '0;
            crc_ok_q        <= 1'b0;
            cnt_q           <= '0;
            idle_q          <= '0;
            id_q            <= '0;
            rtr_q           <= 1'b0;
            dlc_q           <= '0;
            last_byte_q     <= '0;
            bus.ack_out     <= 1'b1;
            bus.RX_BUSY     <= 1'b0;
            bus.RX_VALID    <= 1'b0;
            bus.RX_ERR      <= 1'b0;
            bus.RX_ERR_CODE <= '0;
            bus.RX_ID       <= '0;
            bus.RX_DLC      <= '0;
            bus.RX_RTR      <= 1'b0;
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                data_q[i]      <= '0;
                bus.RX_DATA[i] <= '0;
            end
        end else begin
            bus.RX_VALID <= 1'b0;
            bus.RX_ERR   <= 1'b0;
            if (err_d != 2'd0) begin
                state_q         <= S_WAIT_IDLE;
                idle_q          <= '0;
                bus.RX_ERR      <= 1'b1;
                bus.RX_ERR_CODE <= err_d;
            end else if (stuff_slot) begin
                run_q  <= 3'd1;
                prev_q <= bus.bit_in;
            end else begin
                if (in_stuff) begin
                    run_q  <= (bus.bit_in == prev_q) ? run_q + 3'd1 : 3'd1;
                    prev_q <= bus.bit_in;
                end
                case (state_q)
                    S_IDLE: if (!bus.bit_in) begin
                        // SOF is the first stuffed bit; CRC of a leading 0 from 0 stays 0
                        state_q     <= S_ID;
                        bus.RX_BUSY <= 1'b1;
                        run_q       <= 3'd1;
                        prev_q      <= 1'b0;
                        crc_q       <= '0;
                        cnt_q       <= '0;
                        for (int unsigned i = 0; i < MAX_BYTES; i++) data_q[i] <= '0;
                    end
                    S_ID: begin
                        crc_q <= crc_d;
                        id_q  <= {id_q[9:0], bus.bit_in};
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd10) begin
                            state_q <= S_CTRL;
                            cnt_q   <= '0;
                        end
                    end
                    S_CTRL: begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd0) rtr_q <= bus.bit_in;
                        if (cnt_q >= 6'd3) dlc_q <= dlc_d;
                        if (cnt_q == 6'd6) begin
                            cnt_q       <= '0;
                            last_byte_q <= 3'(nbytes - 4'd1);
                            state_q     <= (nbytes == 4'd0) ? S_CRC : S_DATA;
                        end
                    end
                    S_DATA: begin
                        crc_q                <= crc_d;
                        data_q[cnt_q[5:3]]   <= {data_q[cnt_q[5:3]][6:0], bus.bit_in};
                        cnt_q                <= cnt_q + 6'd1;
                        if (cnt_q == {last_byte_q, 3'b111}) begin
                            cnt_q   <= '0;
                            state_q <= S_CRC;
                        end
                    end
                    S_CRC: begin
                        crc_rx_q <= {crc_rx_q[12:0], bus.bit_in};
                        cnt_q    <= cnt_q + 6'd1;
                        if (cnt_q == 6'd14) begin
                            crc_ok_q <= ({crc_rx_q, bus.bit_in} == crc_q);
                            cnt_q    <= '0;
                            state_q  <= S_CRC_DEL;
                        end
                    end
                    S_CRC_DEL: begin
                        if (crc_ok_q) bus.ack_out <= 1'b0;
                        state_q <= S_ACK;
                    end
                    S_ACK: begin
                        bus.ack_out <= 1'b1;
                        state_q     <= S_ACK_DEL;
                    end
                    S_ACK_DEL: begin
                        cnt_q   <= '0;
                        state_q <= S_EOF;
                    end
                    S_EOF: begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd6) begin
                            state_q      <= S_IDLE;
                            bus.RX_BUSY  <= 1'b0;
                            bus.RX_VALID <= 1'b1;
                            bus.RX_ID    <= id_q;
                            bus.RX_DLC   <= dlc_q;
                            bus.RX_RTR   <= rtr_q;
                            for (int unsigned i = 0; i < MAX_BYTES; i++) bus.RX_DATA[i] <= data_q[i];
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (!bus.bit_in) begin
                            idle_q <= '0;
                        end else if (idle_q == IW'(IDLE_BITS - 1)) begin
                            state_q     <= S_IDLE;
                            bus.RX_BUSY <= 1'b0;
                        end else begin
                            idle_q <= idle_q + IW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_can_rx_deframer.sv
// Directed bench for can_rx_deframer: builds stuffed CAN frames with a long-division CRC
// reference, plays them one bit per clock and checks strobes, ACK slot and outputs.
module tb_can_rx_deframer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_rx_deframer_if #(.MAX_BYTES(8)) bus ();
    can_rx_deframer #(.MAX_BYTES(8), .IDLE_BITS(11)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    bit         raw[$];
    bit         stream[$];
    logic [7:0] tx_data [8];
    int         ack_idx;
    int         eof_idx;

    logic       obs_ack   [512];
    logic       obs_busy  [512];
    logic       obs_valid [512];
    logic       obs_err   [512];
    logic [1:0] obs_code  [512];
    int         n_valid;
    int         n_err;
    logic [10:0] cap_id   [2];
    logic [3:0]  cap_dlc  [2];
    logic        cap_rtr  [2];
    logic [7:0]  cap_data [2][8];

    // CRC-15 as the remainder of message * x^15 divided by x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
    function automatic logic [14:0] ref_crc();
        logic [15:0] r;
        int n;
        r = '0;
        n = raw.size();
        for (int k = 0; k < n + 15; k++) begin
            r = {r[14:0], (k < n) ? logic'(raw[k]) : 1'b0};
            if (r[15]) r = r ^ 16'hC599;
        end
        return r[14:0];
    endfunction

    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc, input int flip);
        logic [14:0] crc;
        int nb;
        bit last;
        int run;
        raw.delete();
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(1'b0);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) raw.push_back(tx_data[b][i]);
        crc = ref_crc();
        if (flip >= 0) raw[19 + flip] = !raw[19 + flip];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        stream.delete();
        last = raw[0];
        run  = 0;
        for (int k = 0; k < raw.size(); k++) begin
            stream.push_back(raw[k]);
            if (k > 0 && raw[k] == last) run++;
            else run = 1;
            last = raw[k];
            if (run == 5 && k < raw.size() - 1) begin
                stream.push_back(!raw[k]);
                last = !raw[k];
                run  = 1;
            end
        end
        stream.push_back(1'b1);
        ack_idx = stream.size();
        stream.push_back(1'b1);
        stream.push_back(1'b1);
        eof_idx = stream.size();
        for (int i = 0; i < 7; i++) stream.push_back(1'b1);
    endtask

    task automatic record(input int k);
        obs_ack[k]   = bus.ack_out;
        obs_busy[k]  = bus.RX_BUSY;
        obs_valid[k] = bus.RX_VALID;
        obs_err[k]   = bus.RX_ERR;
        obs_code[k]  = bus.RX_ERR_CODE;
        if (bus.RX_VALID) begin
            if (n_valid < 2) begin
                cap_id[n_valid]  = bus.RX_ID;
                cap_dlc[n_valid] = bus.RX_DLC;
                cap_rtr[n_valid] = bus.RX_RTR;
                for (int b = 0; b < 8; b++) cap_data[n_valid][b] = bus.RX_DATA[b];
            end
            n_valid++;
        end
        if (bus.RX_ERR) n_err++;
    endtask

    // obs[k] holds the outputs one cycle after stream bit k was sampled
    task automatic send_stream(input int n_tail);
        int total;
        total   = stream.size() + n_tail;
        n_valid = 0;
        n_err   = 0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            if (i > 0) record(i - 1);
            bus.bit_in = (i < stream.size()) ? logic'(stream[i]) : 1'b1;
        end
        @(negedge clk);
        record(total - 1);
    endtask

    task automatic set_good_data();
        tx_data = '{8'h55, 8'h32, 8'h18, 8'h10, 8'h01, 8'h05, 8'hEE, 8'hEE};
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (bus.ack_out !== 1'b1) begin n_fail++; $display("FAIL reset_ack: got %b expected 1", bus.ack_out); end
        n_checks++; if (bus.RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.RX_BUSY); end
        n_checks++; if (bus.RX_VALID !== 1'b0 || bus.RX_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got valid=%b err=%b expected 0 0", bus.RX_VALID, bus.RX_ERR); end
        n_checks++; if (bus.RX_ERR_CODE !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", bus.RX_ERR_CODE); end
        n_checks++; if (bus.RX_ID !== 11'h0 || bus.RX_DLC !== 4'h0 || bus.RX_RTR !== 1'b0) begin n_fail++; $display("FAIL reset_fields: got id=%h dlc=%h rtr=%b expected 0 0 0", bus.RX_ID, bus.RX_DLC, bus.RX_RTR); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (bus.RX_DATA[b] !== 8'h00) begin n_fail++; $display("FAIL reset_data%0d: got %h expected 00", b, bus.RX_DATA[b]); end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.RX_BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.RX_BUSY); end
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [8];
        exp_d = '{8'h55, 8'h32, 8'h18, 8'h10, 8'h01, 8'h05, 8'h00, 8'h00};
        set_good_data();
        build_frame(11'h150, 1'b0, 4'd6, -1);
        send_stream(16);
        n_checks++; if (obs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL good_busy_rise: got %b expected 1", obs_busy[0]); end
        n_checks++; if (obs_ack[ack_idx-2] !== 1'b1) begin n_fail++; $display("FAIL good_ack_before: got %b expected 1", obs_ack[ack_idx-2]); end
        n_checks++; if (obs_ack[ack_idx-1] !== 1'b0) begin n_fail++; $display("FAIL good_ack_slot: got %b expected 0", obs_ack[ack_idx-1]); end
        n_checks++; if (obs_ack[ack_idx] !== 1'b1) begin n_fail++; $display("FAIL good_ack_after: got %b expected 1", obs_ack[ack_idx]); end
        n_checks++; if (obs_valid[eof_idx+5] !== 1'b0) begin n_fail++; $display("FAIL good_valid_early: got %b expected 0", obs_valid[eof_idx+5]); end
        n_checks++; if (obs_valid[eof_idx+6] !== 1'b1) begin n_fail++; $display("FAIL good_valid_time: got %b expected 1", obs_valid[eof_idx+6]); end
        n_checks++; if (obs_busy[eof_idx+6] !== 1'b0) begin n_fail++; $display("FAIL good_busy_fall: got %b expected 0", obs_busy[eof_idx+6]); end
        n_checks++; if (n_valid !== 1 || n_err !== 0) begin n_fail++; $display("FAIL good_pulses: got valid=%0d err=%0d expected 1 0", n_valid, n_err); end
        n_checks++; if (cap_id[0] !== 11'h150 || cap_dlc[0] !== 4'd6 || cap_rtr[0] !== 1'b0) begin n_fail++; $display("FAIL good_fields: got id=%h dlc=%0d rtr=%b expected 150 6 0", cap_id[0], cap_dlc[0], cap_rtr[0]); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_data[0][b] !== exp_d[b]) begin n_fail++; $display("FAIL good_data%0d: got %h expected %h", b, cap_data[0][b], exp_d[b]); end
        end
    endtask

    task automatic test_stuff_error();
        int highs_missing;
        set_good_data();
        build_frame(11'h150, 1'b0, 4'd6, -1);
        for (int k = 6; k <= 11; k++) stream[k] = 1'b0;
        stream = stream[0:11];
        send_stream(20);
        highs_missing = 0;
        for (int k = 11; k <= 21; k++) if (obs_busy[k] !== 1'b1) highs_missing++;
        n_checks++; if (obs_err[10] !== 1'b0) begin n_fail++; $display("FAIL stuff_err_early: got %b expected 0", obs_err[10]); end
        n_checks++; if (obs_err[11] !== 1'b1 || obs_code[11] !== 2'd1) begin n_fail++; $display("FAIL stuff_err: got err=%b code=%0d expected 1 1", obs_err[11], obs_code[11]); end
        n_checks++; if (n_err !== 1 || n_valid !== 0) begin n_fail++; $display("FAIL stuff_pulses: got err=%0d valid=%0d expected 1 0", n_err, n_valid); end
        n_checks++; if (highs_missing !== 0) begin n_fail++; $display("FAIL stuff_busy_hold: got %0d low cycles expected 0", highs_missing); end
        n_checks++; if (obs_busy[22] !== 1'b0) begin n_fail++; $display("FAIL stuff_busy_release: got %b expected 0", obs_busy[22]); end
        n_checks++; if (bus.RX_ID !== 11'h150 || bus.RX_DLC !== 4'd6 || bus.RX_DATA[0] !== 8'h55) begin n_fail++; $display("FAIL stuff_keep: got id=%h dlc=%0d d0=%h expected 150 6 55", bus.RX_ID, bus.RX_DLC, bus.RX_DATA[0]); end
    endtask

    task automatic test_crc_error();
        set_good_data();
        build_frame(11'h150, 1'b0, 4'd6, 3);
        send_stream(16);
        n_checks++; if (obs_ack[ack_idx-1] !== 1'b1) begin n_fail++; $display("FAIL crc_ack: got %b expected 1", obs_ack[ack_idx-1]); end
        n_checks++; if (obs_err[ack_idx] !== 1'b0) begin n_fail++; $display("FAIL crc_err_early: got %b expected 0", obs_err[ack_idx]); end
        n_checks++; if (obs_err[ack_idx+1] !== 1'b1 || obs_code[ack_idx+1] !== 2'd2) begin n_fail++; $display("FAIL crc_err: got err=%b code=%0d expected 1 2", obs_err[ack_idx+1], obs_code[ack_idx+1]); end
        n_checks++; if (n_err !== 1 || n_valid !== 0) begin n_fail++; $display("FAIL crc_pulses: got err=%0d valid=%0d expected 1 0", n_err, n_valid); end
    endtask

    task automatic test_form_error();
        set_good_data();
        build_frame(11'h150, 1'b0, 4'd6, -1);
        stream[eof_idx+3] = 1'b0;
        send_stream(16);
        n_checks++; if (obs_ack[ack_idx-1] !== 1'b0) begin n_fail++; $display("FAIL form_ack: got %b expected 0", obs_ack[ack_idx-1]); end
        n_checks++; if (obs_err[eof_idx+2] !== 1'b0) begin n_fail++; $display("FAIL form_err_early: got %b expected 0", obs_err[eof_idx+2]); end
        n_checks++; if (obs_err[eof_idx+3] !== 1'b1 || obs_code[eof_idx+3] !== 2'd3) begin n_fail++; $display("FAIL form_err: got err=%b code=%0d expected 1 3", obs_err[eof_idx+3], obs_code[eof_idx+3]); end
        n_checks++; if (n_err !== 1 || n_valid !== 0) begin n_fail++; $display("FAIL form_pulses: got err=%0d valid=%0d expected 1 0", n_err, n_valid); end
    endtask

    task automatic test_remote_frame();
        tx_data = '{default: 8'hA5};
        build_frame(11'h123, 1'b1, 4'd3, -1);
        send_stream(16);
        n_checks++; if (n_valid !== 1 || n_err !== 0) begin n_fail++; $display("FAIL rtr_pulses: got valid=%0d err=%0d expected 1 0", n_valid, n_err); end
        n_checks++; if (cap_id[0] !== 11'h123 || cap_dlc[0] !== 4'd3 || cap_rtr[0] !== 1'b1) begin n_fail++; $display("FAIL rtr_fields: got id=%h dlc=%0d rtr=%b expected 123 3 1", cap_id[0], cap_dlc[0], cap_rtr[0]); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_data[0][b] !== 8'h00) begin n_fail++; $display("FAIL rtr_data%0d: got %h expected 00", b, cap_data[0][b]); end
        end
        n_checks++; if (bus.RX_ERR_CODE !== 2'd3) begin n_fail++; $display("FAIL rtr_code_held: got %0d expected 3", bus.RX_ERR_CODE); end
    endtask

    task automatic test_dlc15();
        logic [7:0] exp_d [8];
        exp_d   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tx_data = exp_d;
        build_frame(11'h2A5, 1'b0, 4'd15, -1);
        send_stream(16);
        n_checks++; if (n_valid !== 1 || n_err !== 0) begin n_fail++; $display("FAIL dlc15_pulses: got valid=%0d err=%0d expected 1 0", n_valid, n_err); end
        n_checks++; if (cap_id[0] !== 11'h2A5 || cap_dlc[0] !== 4'd15 || cap_rtr[0] !== 1'b0) begin n_fail++; $display("FAIL dlc15_fields: got id=%h dlc=%0d rtr=%b expected 2a5 15 0", cap_id[0], cap_dlc[0], cap_rtr[0]); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_data[0][b] !== exp_d[b]) begin n_fail++; $display("FAIL dlc15_data%0d: got %h expected %h", b, cap_data[0][b], exp_d[b]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        set_good_data();
        build_frame(11'h150, 1'b0, 4'd6, -1);
        stream = stream[0:29];
        send_stream(0);
        n_checks++; if (obs_busy[29] !== 1'b1 || n_err !== 0) begin n_fail++; $display("FAIL midrst_before: got busy=%b err=%0d expected 1 0", obs_busy[29], n_err); end
        rst        = 1'b1;
        bus.bit_in = 1'b1;
        #1;
        n_checks++; if (bus.ack_out !== 1'b1 || bus.RX_BUSY !== 1'b0 || bus.RX_VALID !== 1'b0 || bus.RX_ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl: got ack=%b busy=%b valid=%b err=%b expected 1 0 0 0", bus.ack_out, bus.RX_BUSY, bus.RX_VALID, bus.RX_ERR); end
        n_checks++; if (bus.RX_ERR_CODE !== 2'd0 || bus.RX_ID !== 11'h0 || bus.RX_DLC !== 4'h0 || bus.RX_RTR !== 1'b0 || bus.RX_DATA[0] !== 8'h00) begin n_fail++; $display("FAIL midrst_fields: got code=%0d id=%h dlc=%h rtr=%b d0=%h expected all 0", bus.RX_ERR_CODE, bus.RX_ID, bus.RX_DLC, bus.RX_RTR, bus.RX_DATA[0]); end
        repeat (2) @(negedge clk);
        n_checks++; if (bus.RX_ERR !== 1'b0) begin n_fail++; $display("FAIL midrst_no_err: got %b expected 0", bus.RX_ERR); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit s1[$];
        int first_len;
        int lows;
        tx_data = '{default: 8'h00};
        build_frame(11'h7FF, 1'b0, 4'd0, -1);
        s1        = stream;
        first_len = s1.size();
        tx_data   = '{default: 8'hAA};
        build_frame(11'h001, 1'b0, 4'd8, -1);
        stream = {s1, stream};
        send_stream(16);
        lows = 0;
        for (int k = 0; k < stream.size() - 1; k++) if (obs_busy[k] !== 1'b1) lows++;
        n_checks++; if (n_valid !== 2 || n_err !== 0) begin n_fail++; $display("FAIL b2b_pulses: got valid=%0d err=%0d expected 2 0", n_valid, n_err); end
        n_checks++; if (obs_valid[first_len-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1_time: got %b expected 1", obs_valid[first_len-1]); end
        n_checks++; if (obs_busy[first_len] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_resume: got %b expected 1", obs_busy[first_len]); end
        n_checks++; if (lows > 1) begin n_fail++; $display("FAIL b2b_busy_gap: got %0d low cycles expected at most 1", lows); end
        n_checks++; if (cap_id[0] !== 11'h7FF || cap_dlc[0] !== 4'd0) begin n_fail++; $display("FAIL b2b_f1_fields: got id=%h dlc=%0d expected 7ff 0", cap_id[0], cap_dlc[0]); end
        n_checks++; if (cap_data[0][0] !== 8'h00 || cap_data[0][7] !== 8'h00) begin n_fail++; $display("FAIL b2b_f1_data: got d0=%h d7=%h expected 00 00", cap_data[0][0], cap_data[0][7]); end
        n_checks++; if (cap_id[1] !== 11'h001 || cap_dlc[1] !== 4'd8) begin n_fail++; $display("FAIL b2b_f2_fields: got id=%h dlc=%0d expected 001 8", cap_id[1], cap_dlc[1]); end
        for (int b = 0; b < 8; b++) begin
            n_checks++; if (cap_data[1][b] !== 8'hAA) begin n_fail++; $display("FAIL b2b_f2_data%0d: got %h expected aa", b, cap_data[1][b]); end
        end
    endtask

    initial begin
        bus.bit_in = 1'b1;
        test_reset();
        test_good_frame();
        test_stuff_error();
        test_crc_error();
        test_form_error();
        test_remote_frame();
        test_dlc15();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
